wall_collision_detector: RTL and testbench

//  Sits directly downstream of the level wall generators and consumes the 26-bit wall pixel bus plus the player sprite pixel.

---
 rtl/wall_collision_detector.sv | 167 ++++++++++++++++
 tb/tb_wall_collision_detector.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/wall_collision_detector.sv
// rtl/wall_collision_detector.sv - per-frame player/wall overlap judge with lives, grace window and game over
module wall_collision_detector #(
    parameter int NWALL        = 26,
    parameter int HIT_THRESH   = 4,
    parameter int GRACE_FRAMES = 60,
    parameter int LIVES_INIT   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             update,
    input  logic [9:0]       xCount,
    input  logic [9:0]       yCount,
    input  logic [NWALL-1:0] wall,
    input  logic             player,
    input  logic [NWALL-1:0] wall_mask,
    output logic             hit_now,
    output logic             coll_pulse,
    output logic [4:0]       last_wall,
    output logic [2:0]       lives,
    output logic             invuln,
    output logic             game_over
);

    localparam int       GW         = (GRACE_FRAMES < 1) ? 1 : $clog2(GRACE_FRAMES + 1);
    localparam logic [GW-1:0] GRACE_INIT = GW'(GRACE_FRAMES);
    localparam logic [8:0]    HIT_T      = 9'(HIT_THRESH);
    localparam logic [2:0]    LIVES_RST  = 3'(LIVES_INIT);

    typedef enum logic [1:0] {
        S_ARMED,
        S_GRACE,
        S_DEAD
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_pix_cnt;
    logic [GW-1:0]   r_grace_cnt;
    logic [GW-1:0]   w_grace_nxt;
    logic [4:0]      r_first_id;
    logic            r_first_vld;
    logic            r_hit_now;
    logic            r_coll_pulse;
    logic [4:0]      r_last_wall;
    logic [2:0]      r_lives;
    logic [2:0]      w_lives_nxt;
    logic            w_coll;

    logic [NWALL-1:0] w_masked;
    logic             w_ov;
    logic [4:0]       w_low_idx;
    logic [8:0]       w_sum;
    logic             w_hit;

    assign w_masked = wall & wall_mask;
    assign w_ov     = player & (|w_masked) & (xCount < 10'd640) & (yCount < 10'd480);
    // Frame total includes an overlap landing on the update cycle itself
    assign w_sum    = {1'b0, r_pix_cnt} + {8'd0, w_ov};
    assign w_hit    = (w_sum >= HIT_T);

    always_comb begin
        w_low_idx = 5'd0;
        for (int i = NWALL - 1; i >= 0; i--) begin
            if (w_masked[i]) begin
                w_low_idx = 5'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_ARMED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_coll      = 1'b0;
        w_lives_nxt = r_lives;
        w_grace_nxt = r_grace_cnt;
        case (r_state)
            S_ARMED: begin
                if (update) begin
                    if (r_lives == 3'd0) begin
                        w_state_nxt = S_DEAD;
                    end else if (w_hit) begin
                        w_coll      = 1'b1;
                        w_lives_nxt = r_lives - 3'd1;
                        if (r_lives == 3'd1) begin
                            w_state_nxt = S_DEAD;
                        end else begin
                            w_state_nxt = S_GRACE;
                            w_grace_nxt = GRACE_INIT;
                        end
                    end
                end
            end
            S_GRACE: begin
                if (update) begin
                    // Leaving on the tick that sees 1 makes the window exactly GRACE_FRAMES ticks
                    if (r_grace_cnt <= GW'(1)) begin
                        w_state_nxt = S_ARMED;
                        w_grace_nxt = '0;
                    end else begin
                        w_grace_nxt = r_grace_cnt - GW'(1);
                    end
                end
            end
            S_DEAD: begin
                w_lives_nxt = 3'd0;
            end
            default: begin
                w_state_nxt = S_ARMED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lives      <= LIVES_RST;
            r_grace_cnt  <= '0;
            r_coll_pulse <= 1'b0;
            r_last_wall  <= 5'd0;
        end else begin
            r_lives      <= w_lives_nxt;
            r_grace_cnt  <= w_grace_nxt;
            r_coll_pulse <= w_coll;
            if (w_coll) begin
                r_last_wall <= r_first_vld ? r_first_id : w_low_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pix_cnt   <= 8'd0;
            r_first_id  <= 5'd0;
            r_first_vld <= 1'b0;
            r_hit_now   <= 1'b0;
        end else begin
            r_hit_now <= w_ov;
            if (update) begin
                r_pix_cnt   <= 8'd0;
                r_first_id  <= 5'd0;
                r_first_vld <= 1'b0;
            end else if (w_ov) begin
                if (r_pix_cnt != 8'hFF) begin
                    r_pix_cnt <= r_pix_cnt + 8'd1;
                end
                if (!r_first_vld) begin
                    r_first_id  <= w_low_idx;
                    r_first_vld <= 1'b1;
                end
            end
        end
    end

    assign hit_now    = r_hit_now;
    assign coll_pulse = r_coll_pulse;
    assign last_wall  = r_last_wall;
    assign lives      = r_lives;
    assign invuln     = (r_state == S_GRACE);
    assign game_over  = (r_state == S_DEAD);

endmodule

// File: tb/tb_wall_collision_detector.sv
// tb/tb_wall_collision_detector.sv - directed self-checking bench for wall_collision_detector
module tb_wall_collision_detector;

    logic        clk;
    logic        rst;
    logic        update;
    logic [9:0]  xCount;
    logic [9:0]  yCount;
    logic [25:0] wall;
    logic        player;
    logic [25:0] wall_mask;
    logic        hit_now;
    logic        coll_pulse;
    logic [4:0]  last_wall;
    logic [2:0]  lives;
    logic        invuln;
    logic        game_over;

    int n_checks = 0;
    int n_fail   = 0;
    int seen;

    localparam logic [25:0] W4  = 26'd1 << 4;
    localparam logic [25:0] W9  = 26'd1 << 9;
    localparam logic [25:0] W2  = 26'd1 << 2;
    localparam logic [25:0] W7  = 26'd1 << 7;

    wall_collision_detector dut (
        .clk        (clk),
        .rst        (rst),
        .update     (update),
        .xCount     (xCount),
        .yCount     (yCount),
        .wall       (wall),
        .player     (player),
        .wall_mask  (wall_mask),
        .hit_now    (hit_now),
        .coll_pulse (coll_pulse),
        .last_wall  (last_wall),
        .lives      (lives),
        .invuln     (invuln),
        .game_over  (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic pl, input logic [25:0] w, input logic upd);
        player = pl;
        wall   = w;
        update = upd;
        @(posedge clk);
        #1;
        player = 1'b0;
        wall   = '0;
        update = 1'b0;
    endtask

    // n overlapping pixels followed by a clean update tick
    task automatic frame(input int n, input logic [25:0] w);
        for (int i = 0; i < n; i++) tick(1'b1, w, 1'b0);
        tick(1'b0, '0, 1'b1);
    endtask

    initial begin
        rst       = 1'b0;
        update    = 1'b0;
        xCount    = 10'd100;
        yCount    = 10'd100;
        wall      = '0;
        player    = 1'b0;
        wall_mask = '1;

        // T1 reset
        tick(1'b1, W4, 1'b1);
        tick(1'b1, W4, 1'b1);
        check("rst_lives", lives, 3);
        check("rst_invuln", invuln, 0);
        check("rst_game_over", game_over, 0);
        check("rst_coll", coll_pulse, 0);
        check("rst_last_wall", last_wall, 0);
        check("rst_hit_now", hit_now, 0);
        rst = 1'b1;
        tick(1'b0, '0, 1'b1);
        check("t1_lives", lives, 3);
        check("t1_coll", coll_pulse, 0);

        // T2 below threshold, counter clears, off-screen pixels ignored
        tick(1'b1, W4, 1'b0);
        check("t2_hit_now", hit_now, 1);
        tick(1'b1, W4, 1'b0);
        tick(1'b1, W4, 1'b0);
        tick(1'b0, '0, 1'b1);
        check("t2_coll", coll_pulse, 0);
        check("t2_lives", lives, 3);
        frame(1, W4);
        check("t2_cleared_coll", coll_pulse, 0);
        xCount = 10'd640;
        tick(1'b1, W4, 1'b0);
        check("t2_x640_hit_now", hit_now, 0);
        frame(10, W4);
        check("t2_x640_coll", coll_pulse, 0);
        xCount = 10'd100;
        tick(1'b1, '0, 1'b0);
        check("t2_nowall_hit_now", hit_now, 0);
        check("t2_lives_end", lives, 3);

        // T3 collision
        frame(10, W4 | W9);
        check("t3_coll", coll_pulse, 1);
        check("t3_last_wall", last_wall, 4);
        check("t3_lives", lives, 2);
        check("t3_invuln", invuln, 1);
        tick(1'b0, '0, 1'b0);
        check("t3_coll_one_clk", coll_pulse, 0);

        // T4 heavy overlap during grace is ignored for exactly 60 updates
        seen = 0;
        for (int i = 1; i <= 60; i++) begin
            frame(5, W4);
            if (coll_pulse) seen++;
            if (i == 59) check("t4_invuln_59", invuln, 1);
        end
        check("t4_invuln_60", invuln, 0);
        check("t4_pulses", seen, 0);
        check("t4_lives", lives, 2);
        tick(1'b1, W9, 1'b0);
        tick(1'b1, W2, 1'b0);
        tick(1'b1, W2, 1'b0);
        tick(1'b1, W2, 1'b0);
        tick(1'b0, '0, 1'b1);
        check("t4_coll", coll_pulse, 1);
        check("t4_last_wall_first", last_wall, 9);
        check("t4_lives_after", lives, 1);

        // T6 async reset during grace with one life left
        for (int i = 0; i < 10; i++) frame(0, '0);
        tick(1'b1, W4, 1'b0);
        check("t6_pre_hit_now", hit_now, 1);
        check("t6_pre_invuln", invuln, 1);
        #3;
        rst = 1'b0;
        #1;
        check("t6_lives", lives, 3);
        check("t6_invuln", invuln, 0);
        check("t6_hit_now", hit_now, 0);
        check("t6_last_wall", last_wall, 0);
        check("t6_game_over", game_over, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // T5 game over, mask and same-cycle boundary
        frame(10, W4);
        check("t5_coll1", coll_pulse, 1);
        check("t5_lives1", lives, 2);
        for (int i = 0; i < 60; i++) frame(0, '0);
        frame(10, W9);
        check("t5_coll2", coll_pulse, 1);
        check("t5_lives2", lives, 1);
        for (int i = 0; i < 60; i++) frame(0, '0);
        check("t5_armed", invuln, 0);
        wall_mask = ~W4;
        frame(10, W4);
        check("t5_mask_coll", coll_pulse, 0);
        check("t5_mask_lives", lives, 1);
        wall_mask = '1;
        tick(1'b1, W7, 1'b0);
        tick(1'b1, W7, 1'b0);
        tick(1'b1, W7, 1'b0);
        tick(1'b1, W7, 1'b1);
        check("t5_same_cycle_coll", coll_pulse, 1);
        check("t5_last_wall", last_wall, 7);
        check("t5_lives0", lives, 0);
        check("t5_game_over", game_over, 1);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            frame(10, W4);
            if (coll_pulse) seen++;
        end
        check("t5_dead_pulses", seen, 0);
        check("t5_dead_lives", lives, 0);
        check("t5_dead_game_over", game_over, 1);
        check("t5_dead_invuln", invuln, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
